// File: rtl/flow_arb_pkg.sv
// Shared types and helpers for the flow_* stream arbiters.
// Pointer storage is sized for up to 256 requesters so the state struct is port-count independent.
package flow_arb_pkg;

  localparam int FLOW_ARB_PTR_W = 8;

  function automatic int flow_arb_idx_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  typedef struct packed {
    logic [FLOW_ARB_PTR_W-1:0] ptr;
    logic                      lock;
  } flow_arb_state_t;

endpackage

// File: rtl/flow_rr_picker.sv
// Rotating-priority encoder: first request at or after ptr_i, wrapping modulo PORTS.
module flow_rr_picker
  import flow_arb_pkg::*;
#(
  parameter int PORTS = 4,
  localparam int INDEX_WIDTH = flow_arb_idx_w(PORTS)
) (
  input  logic [PORTS-1:0]          req_i,
  input  logic [FLOW_ARB_PTR_W-1:0] ptr_i,
  output logic [INDEX_WIDTH-1:0]    winner_o,
  output logic                      any_o
);

  // Scan from farthest to nearest offset so the nearest request is the last one written.
  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % PORTS]) begin
        winner_o = INDEX_WIDTH'((int'(ptr_i) + k) % PORTS);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flow_rr_arbiter.sv
// Round-robin arbiter merging PORTS valid/ready streams into one registered output stream.
// Define FLOW_RR_ARBITER_LOCK_EN to keep the grant on one port for a whole packet (until in_last).
module flow_rr_arbiter
  import flow_arb_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int DATA_WIDTH = 8,
  localparam int INDEX_WIDTH = flow_arb_idx_w(PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            in_valid,
  output logic [PORTS-1:0]            in_ready,
  input  logic [PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [PORTS-1:0]            in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_last,
  output logic [INDEX_WIDTH-1:0]      out_index
);

  logic [FLOW_ARB_PTR_W-1:0] ptr;
  logic [FLOW_ARB_PTR_W-1:0] ptr_adv;
  logic [PORTS-1:0]          eligible;
  logic [INDEX_WIDTH-1:0]    winner;
  logic                      any_valid;
  logic                      load;
  logic                      accept;

  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
  logic [INDEX_WIDTH-1:0]    out_index_q, out_index_d;

`ifdef FLOW_RR_ARBITER_LOCK_EN
  flow_arb_state_t state_q, state_d;

  assign ptr = state_q.ptr;
  // While a packet is open only its owner is eligible, even when it is not presenting a beat.
  assign eligible = state_q.lock ? (in_valid & (PORTS'(1) << ptr)) : in_valid;
`else
  logic [FLOW_ARB_PTR_W-1:0] ptr_q, ptr_d;

  assign ptr      = ptr_q;
  assign eligible = in_valid;
`endif

  flow_rr_picker #(
    .PORTS(PORTS)
  ) u_picker (
    .req_i   (eligible),
    .ptr_i   (ptr),
    .winner_o(winner),
    .any_o   (any_valid)
  );

  // The output register can take a beat when empty or drained this cycle; reset blocks acceptance.
  assign load    = !out_valid_q || out_ready;
  assign accept  = load && any_valid && !rst;
  assign ptr_adv = (int'(winner) == PORTS - 1) ? '0 : FLOW_ARB_PTR_W'(int'(winner) + 1);

  always_comb begin
    in_ready = '0;
    if (accept) begin
      in_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_index_d = out_index_q;
    if (load) begin
      out_valid_d = any_valid;
    end
    if (accept) begin
      out_data_d  = in_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
      out_last_d  = in_last[winner];
      out_index_d = winner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_index_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_index_q <= out_index_d;
    end
  end

`ifdef FLOW_RR_ARBITER_LOCK_EN
  // A non-last beat opens a packet and parks the pointer on its owner.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (in_last[winner]) begin
        state_d.lock = 1'b0;
        state_d.ptr  = ptr_adv;
      end else begin
        state_d.lock = 1'b1;
        state_d.ptr  = FLOW_ARB_PTR_W'(winner);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign ptr_d = accept ? ptr_adv : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_index = out_index_q;

endmodule

// File: tb/tb_flow_rr_arbiter.sv
// Self-checking bench for flow_rr_arbiter: reference arbitration model plus an in-order beat scoreboard.
// Honours FLOW_RR_ARBITER_LOCK_EN the same way as the design.
module tb_flow_rr_arbiter;

  localparam int PORTS = 4;
  localparam int DW    = 8;
  localparam int IW    = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [IW-1:0] idx;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PORTS-1:0]  in_valid = '0;
  logic [PORTS-1:0]  in_ready;
  logic [PORTS*DW-1:0] in_data = '0;
  logic [PORTS-1:0]  in_last = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic [IW-1:0]     out_index;

  beat_t             sb[$];
  int                n_cmp = 0;
  int                n_err = 0;
  logic              m_valid = 1'b0;
  int                m_ptr = 0;
  logic              m_lock = 1'b0;
  logic [PORTS-1:0]  hs_vec = '0;

  flow_rr_arbiter #(
    .PORTS(PORTS),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .out_index(out_index)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang want completion");
    $fatal(1, "watchdog");
  end

  // One clock: check combinational/held outputs against the model at negedge, then advance the model.
  task automatic cycle();
    logic [PORTS-1:0] elig, rdy_m;
    int               w;
    logic             any_m, load_m, hs_m;
    beat_t            b;
    @(negedge clk);
    load_m = !m_valid || out_ready;
    elig   = in_valid;
`ifdef FLOW_RR_ARBITER_LOCK_EN
    if (m_lock) elig = in_valid & (PORTS'(1) << m_ptr);
`endif
    any_m = 1'b0;
    w     = 0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      if (elig[(m_ptr + k) % PORTS]) begin
        w     = (m_ptr + k) % PORTS;
        any_m = 1'b1;
      end
    end
    hs_m  = !rst && load_m && any_m;
    rdy_m = hs_m ? (PORTS'(1) << w) : '0;
    n_cmp++;
    if (in_ready !== rdy_m) begin
      n_err++;
      $display("FAIL in_ready @%0t: got %b want %b", $time, in_ready, rdy_m);
    end
    n_cmp++;
    if (out_valid !== m_valid) begin
      n_err++;
      $display("FAIL out_valid @%0t: got %b want %b", $time, out_valid, m_valid);
    end
    if (m_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard @%0t: got beat %h with nothing expected", $time, out_data);
      end else begin
        b = sb[0];
        if ({out_data, out_last, out_index} !== b) begin
          n_err++;
          $display("FAIL out_beat @%0t: got data=%h last=%b idx=%0d want data=%h last=%b idx=%0d",
                   $time, out_data, out_last, out_index, b.data, b.last, b.idx);
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
    hs_vec = in_valid & in_ready;
    if (hs_m) begin
      b.data = in_data[w*DW +: DW];
      b.last = in_last[w];
      b.idx  = IW'(w);
      sb.push_back(b);
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      m_lock  = 1'b0;
      sb.delete();
    end else if (load_m) begin
      m_valid = any_m;
      if (any_m) begin
`ifdef FLOW_RR_ARBITER_LOCK_EN
        if (in_last[w]) begin
          m_lock = 1'b0;
          m_ptr  = (w + 1) % PORTS;
        end else begin
          m_lock = 1'b1;
          m_ptr  = w;
        end
`else
        m_ptr = (w + 1) % PORTS;
`endif
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = '1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    n_cmp++;
    if (in_ready !== '0) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 0000", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || out_index !== 2'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b d=%h l=%b i=%0d want 0/00/0/0",
               out_valid, out_data, out_last, out_index);
    end
    rst      = 1'b0;
    in_valid = '0;
    cycle();
  endtask

  task automatic test_rotation();
    int            exp_idx[5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] exp_dat[5] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    out_ready = 1'b1;
    in_data   = {8'h33, 8'h22, 8'h11, 8'h00};
    in_last   = '0;
    in_valid  = '1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_cmp++;
      if (out_valid !== 1'b1 || int'(out_index) != exp_idx[i] || out_data !== exp_dat[i]) begin
        n_err++;
        $display("FAIL rotation[%0d]: got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h",
                 i, out_valid, out_index, out_data, exp_idx[i], exp_dat[i]);
      end
    end
    in_valid = '0;
    cycle();
    cycle();
  endtask

  task automatic test_stall();
    in_data               = '0;
    in_data[2*DW +: DW]   = 8'hA5;
    in_last               = 4'b0100;
    in_valid              = 4'b0100;
    out_ready             = 1'b0;
    cycle();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_index !== 2'd2) begin
      n_err++;
      $display("FAIL stall_capture: got v=%b data=%h idx=%0d want 1/A5/2", out_valid, out_data, out_index);
    end
    in_data[2*DW +: DW] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (in_ready !== '0) begin
        n_err++;
        $display("FAIL stall_in_ready[%0d]: got %b want 0000", i, in_ready);
      end
      cycle();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_index !== 2'd2) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v=%b data=%h idx=%0d want 1/A5/2", i, out_valid, out_data, out_index);
      end
    end
    out_ready = 1'b1;
    cycle();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || out_index !== 2'd2) begin
      n_err++;
      $display("FAIL stall_refill: got v=%b data=%h idx=%0d want 1/5A/2", out_valid, out_data, out_index);
    end
    in_valid = '0;
    cycle();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_no_dup: got out_valid=%b want 0", out_valid);
    end
    cycle();
  endtask

  task automatic test_wrap();
    in_data             = '0;
    in_data[0*DW +: DW] = 8'h40;
    in_data[3*DW +: DW] = 8'h73;
    in_last             = 4'b1001;
    in_valid            = 4'b1001;
    out_ready           = 1'b1;
    cycle();
    n_cmp++;
    if (out_index !== 2'd3 || out_data !== 8'h73) begin
      n_err++;
      $display("FAIL wrap_first: got idx=%0d data=%h want 3/73", out_index, out_data);
    end
    in_valid = 4'b0001;
    cycle();
    n_cmp++;
    if (out_index !== 2'd0 || out_data !== 8'h40) begin
      n_err++;
      $display("FAIL wrap_second: got idx=%0d data=%h want 0/40", out_index, out_data);
    end
    in_valid = '0;
    cycle();
    cycle();
  endtask

  task automatic test_reset_mid();
    in_data             = '0;
    in_data[1*DW +: DW] = 8'h10;
    in_data[3*DW +: DW] = 8'h30;
    in_last             = '0;
    in_valid            = 4'b1010;
    out_ready           = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      for (int p = 0; p < PORTS; p++)
        if (hs_vec[p]) in_data[p*DW +: DW] = in_data[p*DW +: DW] + 8'h01;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== '0) begin
      n_err++;
      $display("FAIL reset_mid_in_ready: got %b want 0000", in_ready);
    end
    cycle();
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || out_index !== 2'd0) begin
      n_err++;
      $display("FAIL reset_mid_clear: got v=%b idx=%0d want 0/0", out_valid, out_index);
    end
    cycle();
    n_cmp++;
    if (out_valid !== 1'b1 || out_index !== 2'd1) begin
      n_err++;
      $display("FAIL reset_mid_regrant: got v=%b idx=%0d want 1/1", out_valid, out_index);
    end
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < PORTS; p++)
        if (hs_vec[p]) in_data[p*DW +: DW] = in_data[p*DW +: DW] + 8'h01;
      cycle();
    end
    in_valid = '0;
    cycle();
    cycle();
  endtask

  task automatic test_random();
    int         wait_cnt[PORTS];
    logic [5:0] seq[PORTS];
    for (int p = 0; p < PORTS; p++) begin
      wait_cnt[p] = 0;
      seq[p]      = '0;
    end
    for (int c = 0; c < 10000; c++) begin
      for (int p = 0; p < PORTS; p++) begin
        if (!in_valid[p] && $urandom_range(0, 3) == 0) begin
          in_valid[p]         = 1'b1;
          in_data[p*DW +: DW] = {2'(p), seq[p]};
          in_last[p]          = 1'($urandom_range(0, 1));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
`ifndef FLOW_RR_ARBITER_LOCK_EN
      for (int p = 0; p < PORTS; p++) begin
        if (in_valid[p]) begin
          if (hs_vec[p]) begin
            wait_cnt[p] = 0;
          end else if (|hs_vec) begin
            wait_cnt[p]++;
            n_cmp++;
            if (wait_cnt[p] >= PORTS) begin
              n_err++;
              $display("FAIL fairness port %0d @%0t: got %0d foreign grants want < %0d",
                       p, $time, wait_cnt[p], PORTS);
            end
          end
        end
      end
`endif
      for (int p = 0; p < PORTS; p++) begin
        if (hs_vec[p]) begin
          in_valid[p] = 1'b0;
          seq[p]      = seq[p] + 6'd1;
        end
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cycle();
      in_valid = in_valid & ~hs_vec;
    end
    in_valid = '0;
  endtask

  task automatic test_packet();
    int got[5];
    int exp_idx[5];
    int b1 = 0;
`ifdef FLOW_RR_ARBITER_LOCK_EN
    exp_idx = '{1, 1, 1, 0, 0};
`else
    exp_idx = '{1, 0, 1, 0, 1};
`endif
    rst      = 1'b1;
    in_valid = '0;
    cycle();
    rst                 = 1'b0;
    out_ready           = 1'b1;
    in_data             = '0;
    in_data[0*DW +: DW] = 8'hC0;
    in_last             = 4'b0001;
    in_valid            = 4'b0001;
    cycle();
    in_valid = '0;
    cycle();
    in_data[0*DW +: DW] = 8'hC1;
    in_data[1*DW +: DW] = 8'hB0;
    in_last             = 4'b0001;
    in_valid            = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      cycle();
      got[i] = int'(out_index);
      if (hs_vec[1]) begin
        b1++;
        in_data[1*DW +: DW] = 8'hB0 + 8'(b1);
        in_last[1]          = (b1 == 2);
        if (b1 == 3) in_valid[1] = 1'b0;
      end
      if (hs_vec[0]) in_data[0*DW +: DW] = in_data[0*DW +: DW] + 8'h01;
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (got[i] != exp_idx[i]) begin
        n_err++;
        $display("FAIL packet_order[%0d]: got idx=%0d want %0d", i, got[i], exp_idx[i]);
      end
    end
    in_valid = '0;
    cycle();
    cycle();
    n_cmp++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL final_drain: got %0d pending beats, out_valid=%b want 0/0", sb.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    test_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
